// File: rtl/spi_master_multi_cs.sv
// SPI master with run-time CPOL/CPHA, one-hot active-low chip selects and
// burst support (chip select held low across words while in WAIT).
`timescale 1ns/1ps
module spi_master_multi_cs #(
    parameter int system_clk_frequency = 50_000_000,
    parameter int spi_clk_frequency    = 5_000_000,
    parameter int data_width           = 8,
    parameter int num_slaves           = 4,
    localparam int CSW = (num_slaves > 1) ? $clog2(num_slaves) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [CSW-1:0]        cs_sel,
    input  logic [data_width-1:0] tx_data,
    output logic [data_width-1:0] rx_data,
    output logic                  done,
    output logic                  busy,
    output logic                  err,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [num_slaves-1:0] cs_n
);

    localparam int HALF = system_clk_frequency / (2 * spi_clk_frequency);
    localparam int CNTW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int EW   = $clog2(2 * data_width + 1);
    localparam logic [CNTW-1:0]       CNT_LOAD = CNTW'(HALF - 1);
    localparam logic [EW-1:0]         EDGES    = EW'(2 * data_width);
    localparam logic [31:0]           NS_U     = 32'(num_slaves);
    localparam logic [num_slaves-1:0] CS_ONE   = num_slaves'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_GAP,
        S_WAIT
    } state_t;

    state_t                r_state;
    logic [CNTW-1:0]       r_cnt;
    logic [EW-1:0]         r_edge;
    logic                  r_cpol;
    logic                  r_cpha;
    logic                  r_cont;
    logic [CSW-1:0]        r_sel;
    logic [data_width-1:0] r_tx;
    logic [data_width-1:0] r_rx;
    logic [data_width-1:0] r_rx_data;
    logic [num_slaves-1:0] r_cs_n;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_err;

    logic                  w_sel_ok;
    logic                  w_tick;
    logic                  w_last;
    logic                  w_sample;
    logic                  w_load_cpha;
    logic [EW-1:0]         w_edge_n;
    logic [data_width-1:0] w_tx_load;
    logic                  w_mosi_load;

    assign w_sel_ok    = 32'(cs_sel) < NS_U;
    assign w_tick      = (r_cnt == '0);
    assign w_last      = (r_edge == EDGES);
    assign w_edge_n    = r_edge + EW'(1);
    // Odd edge numbers are leading edges; CPHA picks which kind samples miso.
    assign w_sample    = w_edge_n[0] ^ r_cpha;
    // A burst continuation keeps the phase chosen by the first word.
    assign w_load_cpha = (r_state == S_IDLE) ? cpha : r_cpha;
    assign w_tx_load   = w_load_cpha ? tx_data : (tx_data << 1);
    assign w_mosi_load = w_load_cpha ? r_mosi : tx_data[data_width-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_edge    <= '0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_cont    <= 1'b0;
            r_sel     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_cs_n    <= '1;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_sel_ok) begin
                            r_cpol  <= cpol;
                            r_cpha  <= cpha;
                            r_sel   <= cs_sel;
                            r_sclk  <= cpol;
                            r_cs_n  <= ~(CS_ONE << cs_sel);
                            r_cont  <= cont;
                            r_tx    <= w_tx_load;
                            r_mosi  <= w_mosi_load;
                            r_cnt   <= CNT_LOAD;
                            r_edge  <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_SETUP;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (start) begin
                        r_err   <= (cs_sel != r_sel);
                        r_cont  <= cont;
                        r_tx    <= w_tx_load;
                        r_mosi  <= w_mosi_load;
                        r_cnt   <= CNT_LOAD;
                        r_edge  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP, S_XFER: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end else if (w_last) begin
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt   <= CNT_LOAD;
                        r_edge  <= w_edge_n;
                        r_sclk  <= ~r_sclk;
                        r_state <= S_XFER;
                        if (w_sample) begin
                            r_rx <= {r_rx[data_width-2:0], miso};
                        end else begin
                            r_mosi <= r_tx[data_width-1];
                            r_tx   <= r_tx << 1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end else begin
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx;
                        if (r_cont) begin
                            r_busy  <= 1'b0;
                            r_state <= S_WAIT;
                        end else begin
                            r_cs_n  <= '1;
                            r_cnt   <= CNT_LOAD;
                            r_state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_data = r_rx_data;
    assign done    = r_done;
    assign busy    = r_busy;
    assign err     = r_err;
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;
    assign cs_n    = r_cs_n;

endmodule
